// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer_if
// Description : Handshake bundle for bit_serializer. Carries the parallel
//               input word channel (in_valid/in_ready/in_data), the serial
//               output channel (out_valid/out_ready/out_bit/out_sel/out_last)
//               and the side-band flush/busy signals.
//               master : the producer/consumer environment around the block
//               slave  : the serializer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_serializer_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [SEL_W-1:0] out_sel;
    logic             out_last;
    logic             busy;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bit,
        input  out_sel,
        input  out_last,
        input  busy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bit,
        output out_sel,
        output out_last,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Accepts a parallel word on a valid/ready handshake and emits
//               it one bit per beat, tagging each bit with its index in the
//               word. Back-to-back words stream with no bubble.
// Ports       : clk    - rising-edge clock
//               resetn - asynchronous active-low reset
//               bus    - bit_serializer_if.slave (flush, input word channel,
//                        serial output channel, busy)
// Parameters  : WIDTH     - bits per word (>= 2)
//               SEL_W     - index width, derived from WIDTH
//               MSB_FIRST - 0: emit index 0..WIDTH-1, 1: WIDTH-1..0
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire               clk,
    input  wire               resetn,
    bit_serializer_if.slave   bus
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    localparam int c_FIRST_INT = MSB_FIRST ? WIDTH - 1 : 0;
    localparam int c_LAST_INT  = MSB_FIRST ? 0 : WIDTH - 1;
    localparam logic [SEL_W-1:0] c_FIRST_IDX = c_FIRST_INT[SEL_W-1:0];
    localparam logic [SEL_W-1:0] c_LAST_IDX  = c_LAST_INT[SEL_W-1:0];

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_word;
    logic [SEL_W-1:0] r_sel;

    logic             w_out_valid;
    logic             w_out_last;
    logic             w_out_beat;
    logic             w_last_beat;
    logic             w_in_ready;
    logic             w_in_beat;
    logic [SEL_W-1:0] w_sel_next;

    // Index stepping direction is fixed at elaboration.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sel_next = r_sel - 1'b1;
        end else begin : g_lsb_first
            assign w_sel_next = r_sel + 1'b1;
        end
    endgenerate

    assign w_out_valid = (r_state == c_SHIFT);
    // Gated by state so an idle block with MSB_FIRST (out_sel=0) never
    // reports a last bit.
    assign w_out_last  = w_out_valid && (r_sel == c_LAST_IDX);
    assign w_out_beat  = w_out_valid && bus.out_ready;
    assign w_last_beat = w_out_beat && w_out_last;
    // Combinational out_ready -> in_ready path lets the next word load on
    // the same edge the last bit leaves, giving 1 bit/cycle sustained.
    assign w_in_ready  = !bus.flush && (!w_out_valid || w_last_beat);
    assign w_in_beat   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_word  <= '0;
            r_sel   <= '0;
        end else if (bus.flush) begin
            // Flush wins over any output beat; the held word is abandoned.
            r_state <= c_IDLE;
        end else if (w_in_beat) begin
            r_state <= c_SHIFT;
            r_word  <= bus.in_data;
            r_sel   <= c_FIRST_IDX;
        end else if (w_last_beat) begin
            // out_sel deliberately holds the final index while idle.
            r_state <= c_IDLE;
        end else if (w_out_beat) begin
            r_sel   <= w_sel_next;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_bit   = r_word[r_sel];
    assign bus.out_sel   = r_sel;
    assign bus.out_last  = w_out_last;
    assign bus.busy      = w_out_valid;

endmodule
`default_nettype wire
